// File: rtl/kgp_pkg.sv
// ============================================================================
//  Module   : kgp_pkg
//  Purpose  : KGP carry codes and the encode/combine helpers for the adder.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package kgp_pkg;

  typedef logic [1:0] kgp_t;

  localparam kgp_t K = 2'b00;
  localparam kgp_t P = 2'b01;
  localparam kgp_t G = 2'b11;

  // Higher group wins unless it only propagates.
  function automatic kgp_t kgp_combine(input kgp_t hi, input kgp_t lo);
    return (hi == P) ? lo : hi;
  endfunction

  function automatic kgp_t kgp_encode(input logic a_bit, input logic b_bit);
    if (a_bit && b_bit)
      return G;
    else if (!a_bit && !b_bit)
      return K;
    else
      return P;
  endfunction

endpackage

`default_nettype wire

// File: rtl/kgp_prefix_level.sv
// ============================================================================
//  Module   : kgp_prefix_level
//  Purpose  : One registered KGP prefix level combining codes DIST apart.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module kgp_prefix_level
  import kgp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIST  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               in_valid,
  input  logic [2*WIDTH+1:0] in_pos,
  input  logic [WIDTH-1:0]   in_prop,
  output logic               out_valid,
  output logic [2*WIDTH+1:0] out_pos,
  output logic [WIDTH-1:0]   out_prop
);

  logic [2*WIDTH+1:0] w_pos;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_pos
    if (i >= DIST) begin : g_comb
      assign w_pos[2*i +: 2] = kgp_combine(in_pos[2*i +: 2], in_pos[2*(i-DIST) +: 2]);
    end else begin : g_pass
      assign w_pos[2*i +: 2] = in_pos[2*i +: 2];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_pos   <= '0;
      out_prop  <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_pos  <= w_pos;
        out_prop <= in_prop;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/kgp_pipelined_adder.sv
// ============================================================================
//  Module   : kgp_pipelined_adder
//  Purpose  : Pipelined KGP prefix adder, y = a + b + cin, valid/ready stream.
//             Define KGP_ADDER_OVF_EN to add the registered out_ovf flag.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module kgp_pipelined_adder
  import kgp_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   y
`ifdef KGP_ADDER_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int LATENCY = $clog2(WIDTH + 1) + 2;
  localparam int LEVELS  = LATENCY - 2;
  localparam int POSW    = 2 * (WIDTH + 1);

  logic              w_en;
  logic [POSW-1:0]   w_enc_pos;
  logic [POSW-1:0]   w_pos  [0:LEVELS];
  logic [WIDTH-1:0]  w_prop [0:LEVELS];
  logic              w_valid[0:LEVELS];
  logic [WIDTH:0]    w_carry;
  logic [WIDTH:0]    w_sum;

  // The whole pipe moves together; only a stalled output can hold it.
  assign w_en     = !out_valid || out_ready;
  assign in_ready = w_en;

  assign w_enc_pos[1:0] = cin ? G : K;
  for (genvar i = 0; i < WIDTH; i++) begin : g_encode
    assign w_enc_pos[2*(i+1) +: 2] = kgp_encode(a[i], b[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_valid[0] <= 1'b0;
      w_pos[0]   <= '0;
      w_prop[0]  <= '0;
    end else if (w_en) begin
      w_valid[0] <= in_valid;
      if (in_valid) begin
        w_pos[0]  <= w_enc_pos;
        w_prop[0] <= a ^ b;
      end
    end
  end

  for (genvar j = 0; j < LEVELS; j++) begin : g_level
    kgp_prefix_level #(
      .WIDTH (WIDTH),
      .DIST  (2**j)
    ) u_level (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (w_en),
      .in_valid  (w_valid[j]),
      .in_pos    (w_pos[j]),
      .in_prop   (w_prop[j]),
      .out_valid (w_valid[j+1]),
      .out_pos   (w_pos[j+1]),
      .out_prop  (w_prop[j+1])
    );
  end

  // After the last level, position i is G exactly when a carry enters bit i.
  for (genvar i = 0; i <= WIDTH; i++) begin : g_carry
    assign w_carry[i] = (w_pos[LEVELS][2*i +: 2] == G);
  end

  assign w_sum = {w_carry[WIDTH], w_prop[LEVELS] ^ w_carry[WIDTH-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      y         <= '0;
`ifdef KGP_ADDER_OVF_EN
      out_ovf   <= 1'b0;
`endif
    end else if (w_en) begin
      out_valid <= w_valid[LEVELS];
      if (w_valid[LEVELS]) begin
        y       <= w_sum;
`ifdef KGP_ADDER_OVF_EN
        out_ovf <= w_carry[WIDTH] ^ w_carry[WIDTH-1];
`endif
      end
    end
  end

endmodule

`default_nettype wire
